// File: rtl/serial_rcv_block.sv
// Asynchronous serial frame receiver: start/data/stop framing, mid-bit sampling,
// ready/read handshake with overrun and framing status.
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | timing to mid start bit, rejecting glitches
// DATA  | sampling NUM_BITS data bits, one per bit period
// STOP  | timing to mid stop bit
// LOAD  | single cycle: commit word or flag framing error
module serial_rcv_block #(
    parameter int NUM_BITS     = 8,
    parameter int CLKS_PER_BIT = 10,
    parameter bit SHIFT_MSB    = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial_in,
    input  logic                data_read,
    output logic [NUM_BITS-1:0] rx_data,
    output logic                data_ready,
    output logic                overrun_error,
    output logic                framing_error
);

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(NUM_BITS + 1);

    localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NUM_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        LOAD
    } state_t;

    state_t state, state_nxt;

    logic                sync1;
    logic                s;
    logic                s_prev;
    logic [CW-1:0]       cyc_cnt;
    logic [BW-1:0]       bit_cnt;
    logic [NUM_BITS-1:0] shifter;
    logic                stop_bit;

    logic                cnt_tc;
    logic                fall;
    logic                cyc_load;
    logic [CW-1:0]       cyc_load_val;
    logic                shift_en;
    logic                stop_capture;

    assign cnt_tc = (cyc_cnt == '0);
    assign fall   = ~s & s_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b1;
            s      <= 1'b1;
            s_prev <= 1'b1;
        end else begin
            sync1  <= serial_in;
            s      <= sync1;
            s_prev <= s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cyc_load     = 1'b0;
        cyc_load_val = CNT_BIT;
        shift_en     = 1'b0;
        stop_capture = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt    = START;
                    cyc_load     = 1'b1;
                    cyc_load_val = CNT_HALF;
                end
            end
            START: begin
                if (cnt_tc) begin
                    if (s) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                        cyc_load  = 1'b1;
                    end
                end
            end
            DATA: begin
                if (cnt_tc) begin
                    shift_en = 1'b1;
                    cyc_load = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_tc) begin
                    stop_capture = 1'b1;
                    state_nxt    = LOAD;
                end
            end
            LOAD: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Down-counter; sits at zero once it reaches terminal count until reloaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            if (cyc_load) begin
                cyc_cnt <= cyc_load_val;
            end else if (state == IDLE) begin
                cyc_cnt <= '0;
            end else if (!cnt_tc) begin
                cyc_cnt <= cyc_cnt - 1'b1;
            end

            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shifter  <= '0;
            stop_bit <= 1'b0;
        end else begin
            if (shift_en) begin
                if (SHIFT_MSB) begin
                    shifter <= {shifter[NUM_BITS-2:0], s};
                end else begin
                    shifter <= {s, shifter[NUM_BITS-1:1]};
                end
            end
            if (stop_capture) begin
                stop_bit <= s;
            end
        end
    end

    // A valid load takes priority over a coincident data_read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data       <= '1;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
        end else if (state == LOAD && stop_bit) begin
            rx_data       <= shifter;
            framing_error <= 1'b0;
            data_ready    <= 1'b1;
            if (data_ready && !data_read) begin
                overrun_error <= 1'b1;
            end
        end else begin
            if (state == LOAD) begin
                framing_error <= 1'b1;
            end
            if (data_read) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_rcv_block.sv
// Bench for serial_rcv_block: two instances (8N/10 LSB-first, 5N/4 MSB-first)
// compared every cycle against a frame-level model, plus fixed scenario checks.
module tb_serial_rcv_block;

    logic       clk;
    logic       rst;
    logic       line8, line5;
    logic       rd8, rd5;
    logic [7:0] rx8;
    logic [4:0] rx5;
    logic       dr8, ov8, fe8;
    logic       dr5, ov5, fe5;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 0;

    serial_rcv_block #(.NUM_BITS(8), .CLKS_PER_BIT(10), .SHIFT_MSB(1'b0)) dut8 (
        .clk(clk), .rst(rst), .serial_in(line8), .data_read(rd8),
        .rx_data(rx8), .data_ready(dr8), .overrun_error(ov8), .framing_error(fe8)
    );

    serial_rcv_block #(.NUM_BITS(5), .CLKS_PER_BIT(4), .SHIFT_MSB(1'b1)) dut5 (
        .clk(clk), .rst(rst), .serial_in(line5), .data_read(rd5),
        .rx_data(rx5), .data_ready(dr5), .overrun_error(ov5), .framing_error(fe5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int NB   [2] = '{8, 5};
    int CPB  [2] = '{10, 4};
    bit MSBF [2] = '{1'b0, 1'b1};

    // model state, per channel
    bit         m_sync1 [2];
    bit         m_s     [2];
    bit         m_sprev [2];
    bit         m_busy  [2];
    int         m_e     [2];
    int         m_word  [2];
    bit         m_stop  [2];
    logic [7:0] m_rx    [2];
    bit         m_dr    [2];
    bit         m_ov    [2];
    bit         m_fe    [2];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at edge t with the inputs held during cycle t-1; leaves the
    // expected outputs for cycle t.
    task automatic model_step(input int c, input bit rv, input bit pin, input bit rd, input int t);
        int  k, n, cp, h, i;
        bit  load_ok;
        n  = NB[c];
        cp = CPB[c];
        h  = cp / 2;
        if (rv) begin
            m_sync1[c] = 1'b1;
            m_s[c]     = 1'b1;
            m_sprev[c] = 1'b1;
            m_busy[c]  = 1'b0;
            m_rx[c]    = (c == 0) ? 8'hFF : 8'h1F;
            m_dr[c]    = 1'b0;
            m_ov[c]    = 1'b0;
            m_fe[c]    = 1'b0;
            return;
        end
        load_ok = 1'b0;
        if (!m_busy[c]) begin
            if (!m_s[c] && m_sprev[c]) begin
                m_busy[c] = 1'b1;
                m_e[c]    = t - 1;
                m_word[c] = 0;
            end
        end else begin
            k = (t - 1) - m_e[c];
            if (k == h) begin
                if (m_s[c]) m_busy[c] = 1'b0;
            end else if (k > h && k < h + (n + 1) * cp && (k - h) % cp == 0) begin
                i = (k - h) / cp - 1;
                if (m_s[c]) m_word[c] |= MSBF[c] ? (1 << (n - 1 - i)) : (1 << i);
            end else if (k == h + (n + 1) * cp) begin
                m_stop[c] = m_s[c];
            end else if (k == h + (n + 1) * cp + 1) begin
                m_busy[c] = 1'b0;
                if (m_stop[c]) load_ok = 1'b1;
                else m_fe[c] = 1'b1;
            end
        end
        if (load_ok) begin
            if (m_dr[c] && !rd) m_ov[c] = 1'b1;
            m_rx[c] = 8'(m_word[c]);
            m_fe[c] = 1'b0;
            m_dr[c] = 1'b1;
        end else if (rd) begin
            m_dr[c] = 1'b0;
            m_ov[c] = 1'b0;
        end
        m_sprev[c] = m_s[c];
        m_s[c]     = m_sync1[c];
        m_sync1[c] = pin;
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        model_step(0, rst, line8, rd8, cyc);
        model_step(1, rst, line5, rd5, cyc);
        if (rst) chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_rx8", rx8, m_rx[0]);
            chk("cmp_dr8", {7'b0, dr8}, {7'b0, m_dr[0]});
            chk("cmp_ov8", {7'b0, ov8}, {7'b0, m_ov[0]});
            chk("cmp_fe8", {7'b0, fe8}, {7'b0, m_fe[0]});
            chk("cmp_rx5", {3'b0, rx5}, m_rx[1]);
            chk("cmp_dr5", {7'b0, dr5}, {7'b0, m_dr[1]});
            chk("cmp_ov5", {7'b0, ov5}, {7'b0, m_ov[1]});
            chk("cmp_fe5", {7'b0, fe5}, {7'b0, m_fe[1]});
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int c, input logic v);
        if (c == 0) line8 = v;
        else line5 = v;
    endtask

    // Drives start, data, stop; stops early after maxc cycles. Line is left at
    // the last driven level.
    task automatic send_frame(input int c, input logic [7:0] word, input bit stop_ok, input int maxc);
        int   n, cp, bi;
        logic v;
        n  = NB[c];
        cp = CPB[c];
        for (int j = 0; j < (n + 2) * cp && j < maxc; j++) begin
            bi = j / cp;
            if (bi == 0) v = 1'b0;
            else if (bi == n + 1) v = stop_ok;
            else v = MSBF[c] ? word[n - bi] : word[bi - 1];
            set_line(c, v);
            wait_cyc(1);
        end
    endtask

    task automatic pulse_read(input int c);
        if (c == 0) rd8 = 1'b1;
        else rd5 = 1'b1;
        wait_cyc(1);
        rd8 = 1'b0;
        rd5 = 1'b0;
    endtask

    task automatic rand_frames(input int c, input int count);
        logic [7:0] w;
        bit         ok;
        repeat (count) begin
            set_line(c, 1'b1);
            wait_cyc($urandom_range(1, 12));
            w  = 8'($urandom);
            ok = ($urandom_range(0, 9) != 0);
            send_frame(c, w, ok, 1000);
            set_line(c, 1'b1);
        end
    endtask

    bit done0, done1;

    initial begin
        rst = 1'b1; line8 = 1'b1; line5 = 1'b1; rd8 = 1'b0; rd5 = 1'b0;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(2);
        chk("rst_rx8", rx8, 8'hFF);
        chk("rst_rx5", {3'b0, rx5}, 8'h1F);
        chk("rst_flags8", {5'b0, ov8, dr8, fe8}, 8'h00);

        // good frame: start driven in cycle p gives E=p+2, ready at E+97
        fork
            send_frame(0, 8'hA5, 1'b1, 1000);
            begin
                wait_cyc(98);
                chk("a5_dr_before", {7'b0, dr8}, 8'h00);
                wait_cyc(1);
                chk("a5_dr_rise", {7'b0, dr8}, 8'h01);
                chk("a5_rx", rx8, 8'hA5);
                chk("a5_fe", {7'b0, fe8}, 8'h00);
            end
        join
        pulse_read(0);
        chk("a5_read_clr", {7'b0, dr8}, 8'h00);

        // reset in the middle of DATA
        send_frame(0, 8'h3C, 1'b1, 40);
        line8 = 1'b1;
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(5);
        chk("midrst_rx", rx8, 8'hFF);
        chk("midrst_flags", {5'b0, ov8, dr8, fe8}, 8'h00);
        send_frame(0, 8'h3C, 1'b1, 1000);
        wait_cyc(2);
        chk("after_rst_rx", rx8, 8'h3C);
        pulse_read(0);

        // overrun, then read coinciding with the second load
        send_frame(0, 8'h11, 1'b1, 1000);
        send_frame(0, 8'h22, 1'b1, 1000);
        wait_cyc(2);
        chk("ovr_ov", {7'b0, ov8}, 8'h01);
        chk("ovr_rx", rx8, 8'h22);
        pulse_read(0);
        chk("ovr_clr", {7'b0, ov8}, 8'h00);
        send_frame(0, 8'h11, 1'b1, 1000);
        fork
            send_frame(0, 8'h22, 1'b1, 1000);
            begin
                wait_cyc(98);
                rd8 = 1'b1;
                wait_cyc(1);
                rd8 = 1'b0;
            end
        join
        wait_cyc(1);
        chk("simul_dr", {7'b0, dr8}, 8'h01);
        chk("simul_ov", {7'b0, ov8}, 8'h00);
        chk("simul_rx", rx8, 8'h22);
        pulse_read(0);

        // framing error, then a break
        send_frame(0, 8'h5A, 1'b0, 1000);
        wait_cyc(50);
        chk("fe_set", {7'b0, fe8}, 8'h01);
        chk("fe_dr", {7'b0, dr8}, 8'h00);
        chk("fe_rx_kept", rx8, 8'h22);
        line8 = 1'b1;
        wait_cyc(20);
        send_frame(0, 8'h5A, 1'b1, 1000);
        wait_cyc(2);
        chk("fe_clear", {7'b0, fe8}, 8'h00);
        chk("fe_good_rx", rx8, 8'h5A);
        pulse_read(0);

        // false start
        line8 = 1'b0;
        wait_cyc(3);
        line8 = 1'b1;
        wait_cyc(20);
        chk("false_rx", rx8, 8'h5A);
        chk("false_dr", {7'b0, dr8}, 8'h00);
        send_frame(0, 8'h96, 1'b1, 1000);
        wait_cyc(2);
        chk("false_next_rx", rx8, 8'h96);
        pulse_read(0);

        // 5-bit MSB-first: ready at E+28 = p+30
        send_frame(1, 8'h13, 1'b1, 1000);
        wait_cyc(1);
        chk("n5_dr_before", {7'b0, dr5}, 8'h00);
        wait_cyc(1);
        chk("n5_rx", {3'b0, rx5}, 8'h13);
        chk("n5_dr", {7'b0, dr5}, 8'h01);
        pulse_read(1);

        // randomized frames on both links with random reads
        done0 = 1'b0;
        done1 = 1'b0;
        fork
            begin rand_frames(0, 25); done0 = 1'b1; end
            begin rand_frames(1, 60); done1 = 1'b1; end
            begin
                while (!(done0 && done1)) begin
                    rd8 = ($urandom_range(0, 7) == 0);
                    rd5 = ($urandom_range(0, 7) == 0);
                    wait_cyc(1);
                end
                rd8 = 1'b0;
                rd5 = 1'b0;
            end
        join

        wait_cyc(10);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: still running at %0d ns, limit 2000000 ns", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_rcv_block.md
# serial_rcv_block

Asynchronous serial frame receiver. It is the receive end of the link whose transmit side is driven by our parallel-to-serial shift register: idle-high line, one low start bit, NUM_BITS data bits in the transmitter's shift order, and one high stop bit. The block synchronizes the line, detects and validates the start bit, and mid-bit samples each bit into an internal serial-to-parallel shifter. It then presents the word to the downstream consumer with a ready/read handshake and overrun and framing status.

## Interface
- NUM_BITS, 8: data bits per frame; legal range ≥ 2.
- CLKS_PER_BIT, 10: clk cycles per serial bit period; legal range ≥ 4. H = floor(CLKS_PER_BIT/2).
- SHIFT_MSB, 0: 1 = first received data bit is rx_data[NUM_BITS-1] (MSB first); 0 = first received bit is rx_data[0] (LSB first).
- clk, input, 1, sole clock, rising edge.
- rst, input, 1, synchronous, active-high reset.
- serial_in, input, 1, asynchronous serial line, idle high.
- data_read, input, 1, consumer pulse; clears data_ready and overrun_error.
- rx_data, output, NUM_BITS, last correctly framed word.
- data_ready, output, 1, a new word is held in rx_data.
- overrun_error, output, 1, a word was overwritten before it was read.
- framing_error, output, 1, the stop bit of the most recent frame sampled low.

## Operation
- **Synchronizer:** serial_in passes through two flops to produce s. Both flops reset to 1. s_prev is a registered copy of s, also reset to 1. All sampling uses s.
- **Edge cycle E:** the first cycle in which s=0 and s_prev=1 while in IDLE.
- **IDLE:**
  - Bit counter and cycle counter are held at 0.
  - On E, go to START and load the cycle counter.
  - A line that is already low on entry to IDLE, such as a break, is not a start. The block waits for s=1 followed by a new falling edge.
- **START:**
  - Sample s at cycle E+H.
  - If s=1, this is a false start: return to IDLE. No output changes.
  - If s=0, go to DATA.
- **DATA:**
  - Data bit i (i = 0..NUM_BITS-1) is sampled at cycle E+H+(i+1)·CLKS_PER_BIT.
  - Each sample shifts into the internal shifter. With SHIFT_MSB=1 the shift is left, entering at bit 0. With SHIFT_MSB=0 the shift is right, entering at bit NUM_BITS-1.
  - After the last bit, go to STOP.
- **STOP:** sample s at cycle X = E+H+(NUM_BITS+1)·CLKS_PER_BIT, then go to LOAD.
- **LOAD (cycle X+1, always exactly one cycle):**
  - **Stop bit = 1:**
    - rx_data ← shifter.
    - framing_error ← 0.
    - data_ready ← 1.
    - overrun_error ← 1 if data_ready was already 1 and data_read is 0 in this cycle; otherwise overrun_error holds.
  - **Stop bit = 0:**
    - framing_error ← 1.
    - rx_data, data_ready and overrun_error are unchanged; the word is discarded.
  - Next state is IDLE.
- **data_read:**
  - Outside a LOAD-with-valid-stop cycle, data_read=1 clears data_ready and overrun_error on the next edge.
  - If data_read coincides with a valid LOAD, the load wins: data_ready = 1 and overrun_error is not set.
- **Transitions mid-frame:** serial_in transitions between sample points are ignored. Only the scheduled samples matter.
- **Counter width:** the cycle counter is wide enough to hold CLKS_PER_BIT-1. The bit counter is wide enough to hold NUM_BITS. Both wrap to 0 on each reload; there is no free-running wrap.

## Timing
- **Reset values:**
  - rx_data = all ones.
  - data_ready = 0, overrun_error = 0, framing_error = 0.
  - State = IDLE.
  - Synchronizer flops and s_prev = 1.
  - Shifter and counters = 0.
- **Reset mid-frame:** rst asserted in any state takes effect at the next edge, restoring all of the above. The partial frame is lost. After rst deasserts, reception resumes with the next falling edge.
- **Pin-to-E latency:** E occurs 2 clk cycles after the edge at which serial_in is first captured low.
- **Output latency:** outputs change at the end of LOAD, so they are visible from cycle X+2 = E+H+(NUM_BITS+1)·CLKS_PER_BIT+2.
- **Back-to-back frames:** IDLE is re-entered at X+2. A falling edge seen at E' ≥ X+2 starts the next frame. Back-to-back frames from a transmitter at the same CLKS_PER_BIT are therefore received without loss.
- **Sustained drift:** a sender running faster than CLKS_PER_BIT is out of scope.
- **Flags are levels:** data_ready and overrun_error persist until data_read or rst. framing_error persists until the next LOAD or rst.

## Test plan
All scenarios use NUM_BITS=8, CLKS_PER_BIT=10 (H=5) unless stated.
- **Reset:** assert rst for 2 cycles mid-DATA of a frame, then idle the line high → rx_data=8'hFF, all flags 0. The next full frame of 0x3C is received correctly.
- **Good frame, SHIFT_MSB=0:** send 0xA5 LSB first (start 0, bits 1,0,1,0,0,1,0,1, stop 1) → data_ready rises exactly at E+97, rx_data=0xA5, framing_error=0. A data_read pulse clears data_ready on the next cycle.
- **Overrun and simultaneity:** send 0x11 then 0x22 back-to-back with no data_read → overrun_error=1, rx_data=0x22. Repeat with data_read asserted exactly in the second LOAD cycle → data_ready=1, overrun_error=0, rx_data=0x22.
- **Framing error and break:** send 0x5A with stop bit 0 → framing_error=1, data_ready stays 0, rx_data keeps its prior value. Hold the line low 50 cycles → no new frame. Return high, then send 0x5A with a good stop → framing_error=0, rx_data=0x5A.
- **False start:** pulse serial_in low for 3 cycles → state returns to IDLE, no output changes. A frame beginning 20 cycles later is received correctly.
- **SHIFT_MSB=1, NUM_BITS=5, CLKS_PER_BIT=4:** send bits 1,0,0,1,1 MSB first → rx_data=5'b10011 at E+2+6·4+2 = E+28.
